booth_pp_accumulator: RTL and testbench

Sequential consumer of radix-4 Booth partial-product rows. Each beat carries one row (`pp`, `p`, `s`) as produced by the team's Booth encoder. The block sign-extends, aligns and accumulates one row per cycle into a `2*WIDTH`-bit product. It sits downstream of the encoder in the iterative (area-optimised) multiplier path and presents the finished product on a valid/ready output.

---
 rtl/booth_pkg.sv | 11 +
 rtl/booth_row_align.sv | 25 ++
 rtl/booth_pp_accumulator.sv | 66 ++++++
 tb/tb_booth_pp_accumulator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and sizing helpers for the Booth partial-product accumulator.
// Provides the accumulator FSM state enum and the row-count / row-index-width functions.
package booth_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} booth_acc_state_t;
  function automatic int booth_num_rows(input int width);
    return width / 2 + 1;
  endfunction
  function automatic int booth_idx_w(input int width);
    return $clog2(booth_num_rows(width));
  endfunction
endpackage

// File: rtl/booth_row_align.sv
// booth_row_align: sign-extends one radix-4 Booth row and aligns it to its weight.
// Ports:
//   pp_in   selected multiple (WIDTH+1 bits), pre-inverted for negative rows
//   p_in    sign-extension bit; row sign is ~p_in
//   s_in    negation correction, +1 at the row LSB
//   row_idx row position within the transaction
//   aligned (sext({~p_in, pp_in}) + s_in) << 2*row_idx, 2*WIDTH bits
module booth_row_align
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]                  pp_in,
  input  logic                            p_in,
  input  logic                            s_in,
  input  logic [booth_idx_w(WIDTH)-1:0]   row_idx,
  output logic [2*WIDTH-1:0]              aligned
);
  logic [WIDTH+1:0]   raw;
  logic [2*WIDTH-1:0] row;
  assign raw = {~p_in, pp_in};
  // Adding s_in after full sign extension keeps the +1 correction exact modulo 2^(2*WIDTH).
  assign row = {{(WIDTH-2){raw[WIDTH+1]}}, raw} + {{(2*WIDTH-1){1'b0}}, s_in};
  assign aligned = row << {row_idx, 1'b0};
endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: accumulates radix-4 Booth rows, one per beat, into a 2*WIDTH-bit product.
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid/in_ready     row beat handshake; pp_in, p_in, s_in carry the row
//   row_idx               index of the next row to be accepted
//   prod_valid/prod_ready product handshake; product is the accumulator modulo 2^(2*WIDTH)
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH:0]                 pp_in,
  input  logic                           p_in,
  input  logic                           s_in,
  output logic [booth_idx_w(WIDTH)-1:0]  row_idx,
  output logic                           prod_valid,
  input  logic                           prod_ready,
  output logic [2*WIDTH-1:0]             product
);
  localparam int NR = booth_num_rows(WIDTH);
  localparam int IW = booth_idx_w(WIDTH);
  booth_acc_state_t   state, state_d;
  logic [IW-1:0]      idx_d;
  logic [2*WIDTH-1:0] acc, acc_d, aligned;
  logic               accept, last;
  booth_row_align #(.WIDTH(WIDTH)) u_align (
    .pp_in   (pp_in),
    .p_in    (p_in),
    .s_in    (s_in),
    .row_idx (row_idx),
    .aligned (aligned)
  );
  // Gating with rst_n forces in_ready low while reset is held, even though state already reads IDLE.
  assign in_ready   = rst_n & (state != DONE);
  assign prod_valid = state == DONE;
  assign product    = acc;
  assign accept     = in_valid & in_ready;
  assign last       = row_idx == IW'(NR - 1);
  always_comb begin
    state_d = state;
    idx_d   = row_idx;
    acc_d   = acc;
    if (state == DONE) state_d = prod_ready ? IDLE : DONE;
    else if (accept) begin
      // Row 0 overwrites so no clear cycle is needed between transactions.
      acc_d   = (state == IDLE) ? aligned : acc + aligned;
      idx_d   = last ? '0 : row_idx + IW'(1);
      state_d = last ? DONE : ACCUM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_idx <= '0;
      acc     <= '0;
    end else begin
      state   <= state_d;
      row_idx <= idx_d;
      acc     <= acc_d;
    end
  end
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb_booth_pp_accumulator: directed self-checking bench for booth_pp_accumulator at WIDTH=8.
module tb_booth_pp_accumulator;
  localparam int W = 8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [W:0]  pp_in;
  logic        p_in;
  logic        s_in;
  logic [2:0]  row_idx;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] product;
  int checks = 0;
  int errors = 0;
  booth_pp_accumulator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pp_in      (pp_in),
    .p_in       (p_in),
    .s_in       (s_in),
    .row_idx    (row_idx),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product)
  );
  always #5 clk = ~clk;
  task automatic send_row(input logic [W:0] pp, input logic p, input logic s);
    pp_in = pp; p_in = p; s_in = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic zero_rows(input int n);
    for (int i = 0; i < n; i++) send_row(9'h000, 1'b1, 1'b0);
  endtask
  task automatic release_product;
    prod_ready = 1'b1;
    @(posedge clk); #1;
    prod_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; prod_ready = 1'b0;
    pp_in = '0; p_in = 1'b1; s_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL reset_prod_valid got %b exp 0", prod_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h exp 0000", product); end
    checks++; if (row_idx !== 3'd0) begin errors++; $display("FAIL reset_row_idx got %0d exp 0", row_idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %b exp 0", in_ready); end
    rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high got %b exp 1", in_ready); end
    @(posedge clk); #1;
  endtask
  task automatic test_single_positive;
    send_row(9'h005, 1'b1, 1'b0);
    checks++; if (row_idx !== 3'd1) begin errors++; $display("FAIL single_row_idx got %0d exp 1", row_idx); end
    zero_rows(3);
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", prod_valid); end
    zero_rows(1);
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", prod_valid); end
    checks++; if (product !== 16'h0005) begin errors++; $display("FAIL single_product got %h exp 0005", product); end
    checks++; if (row_idx !== 3'd0) begin errors++; $display("FAIL single_idx_wrap got %0d exp 0", row_idx); end
    release_product;
  endtask
  task automatic test_negative_align;
    send_row(9'h1FA, 1'b0, 1'b1);
    zero_rows(4);
    checks++; if (product !== 16'hFFFB) begin errors++; $display("FAIL negative_product got %h exp fffb", product); end
    release_product;
    zero_rows(1);
    send_row(9'h003, 1'b1, 1'b0);
    zero_rows(3);
    checks++; if (product !== 16'h000C) begin errors++; $display("FAIL align_product got %h exp 000c", product); end
    release_product;
    send_row(9'h100, 1'b1, 1'b0);
    zero_rows(3);
    send_row(9'h0FF, 1'b1, 1'b0);
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL wrap_product got %h exp 0000", product); end
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", prod_valid); end
    release_product;
  endtask
  task automatic test_gaps_backpressure;
    send_row(9'h001, 1'b1, 1'b0);
    send_row(9'h002, 1'b1, 1'b0);
    send_row(9'h003, 1'b1, 1'b0);
    pp_in = 9'h1FF; p_in = 1'b0; s_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (row_idx !== 3'd3) begin errors++; $display("FAIL gap_row_idx got %0d exp 3", row_idx); end
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got %b exp 0", prod_valid); end
    send_row(9'h001, 1'b1, 1'b0);
    zero_rows(1);
    checks++; if (product !== 16'h0079) begin errors++; $display("FAIL gap_product got %h exp 0079", product); end
    pp_in = 9'h0AA; p_in = 1'b1; s_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (product !== 16'h0079) begin errors++; $display("FAIL hold_product cycle %0d got %h exp 0079", i, product); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle %0d got %b exp 0", i, in_ready); end
      checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cycle %0d got %b exp 1", i, prod_valid); end
    end
    in_valid = 1'b0;
    release_product;
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b exp 0", prod_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_reset_mid;
    send_row(9'h055, 1'b1, 1'b0);
    send_row(9'h033, 1'b1, 1'b0);
    rst_n = 1'b0; #1;
    checks++; if (row_idx !== 3'd0) begin errors++; $display("FAIL midreset_row_idx got %0d exp 0", row_idx); end
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", prod_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL midreset_product got %h exp 0000", product); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_row(9'h001, 1'b1, 1'b0);
    checks++; if (row_idx !== 3'd1) begin errors++; $display("FAIL midreset_restart_idx got %0d exp 1", row_idx); end
    zero_rows(4);
    checks++; if (product !== 16'h0001) begin errors++; $display("FAIL midreset_product_after got %h exp 0001", product); end
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL midreset_valid_after got %b exp 1", prod_valid); end
    release_product;
  endtask
  task automatic test_back_to_back;
    prod_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pp_in = (i == 0) ? 9'h002 : 9'h000; p_in = 1'b1; s_in = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL b2b_a_valid got %b exp 1", prod_valid); end
    checks++; if (product !== 16'h0002) begin errors++; $display("FAIL b2b_a_product got %h exp 0002", product); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_in_ready got %b exp 0", in_ready); end
    pp_in = 9'h0FF; p_in = 1'b1; s_in = 1'b0;
    @(posedge clk); #1;
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b exp 0", prod_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (row_idx !== 3'd1) begin errors++; $display("FAIL b2b_b_row0_idx got %0d exp 1", row_idx); end
    for (int i = 1; i < 5; i++) begin
      pp_in = (i == 4) ? 9'h1FE : 9'h000; p_in = (i == 4) ? 1'b0 : 1'b1; s_in = (i == 4);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (prod_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid got %b exp 1", prod_valid); end
    checks++; if (product !== 16'hFFFF) begin errors++; $display("FAIL b2b_b_product got %h exp ffff", product); end
    @(posedge clk); #1;
    prod_ready = 1'b0;
    checks++; if (prod_valid !== 1'b0) begin errors++; $display("FAIL b2b_final_valid got %b exp 0", prod_valid); end
  endtask
  initial begin
    test_reset;
    test_single_positive;
    test_negative_align;
    test_gaps_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
